// File: rtl/pc_update_unit_pkg.sv
// Shared MIPS datapath constants and the next-PC source encoding used by the
// PC update logic.
package mips_pkg;
  localparam int XLEN    = 32;
  localparam int PC_INCR = 4;
  localparam int SEXT_W  = 16;
  localparam int JIDX_W  = 26;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

  // Branch immediate becomes a signed word offset.
  function automatic logic [XLEN-1:0] sext_shl2(input logic [SEXT_W-1:0] imm);
    logic [XLEN-1:0] ext;
    ext = {{(XLEN-SEXT_W){imm[SEXT_W-1]}}, imm};
    return ext << 2;
  endfunction
endpackage

// File: rtl/pc_update_unit_if.sv
// Control/datapath bundle between the executing stage and the PC update unit.
interface pc_update_unit_if;
  import mips_pkg::*;

  logic [XLEN-1:0]   current_pc;
  logic [JIDX_W-1:0] ins_offset;
  logic              zero_alu;
  logic              con_beq;
  logic              con_bneq;
  logic              con_jump;
  logic [XLEN-1:0]   next_pc;

  modport master (
    output current_pc, ins_offset, zero_alu, con_beq, con_bneq, con_jump,
    input  next_pc
  );

  modport slave (
    input  current_pc, ins_offset, zero_alu, con_beq, con_bneq, con_jump,
    output next_pc
  );
endinterface

// File: rtl/pc_update_unit_target_calc.sv
// Combinational candidate-address generator: sequential, PC-relative branch
// and pseudo-direct jump targets.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]   i_current_pc,
  input  logic [JIDX_W-1:0] i_ins_offset,
  output logic [XLEN-1:0]   o_pc_plus4,
  output logic [XLEN-1:0]   o_branch_target,
  output logic [XLEN-1:0]   o_jump_target
);
  logic [XLEN-1:0] w_pc_plus4;

  // All adds wrap modulo 2^XLEN; alignment of current_pc is not enforced.
  assign w_pc_plus4      = i_current_pc + XLEN'(PC_INCR);
  assign o_pc_plus4      = w_pc_plus4;
  assign o_branch_target = w_pc_plus4 + sext_shl2(i_ins_offset[SEXT_W-1:0]);
  assign o_jump_target   = {w_pc_plus4[XLEN-1:XLEN-4], i_ins_offset, 2'b00};
endmodule

// File: rtl/pc_update_unit.sv
// Next-PC select and register: jump beats taken branch beats PC+4, result
// registered once per cycle.
module pc_update_unit
  import mips_pkg::*;
#(
  parameter int              XLEN_P   = XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  pc_update_unit_if.slave    bus
);
  logic [XLEN_P-1:0] w_pc_plus4;
  logic [XLEN_P-1:0] w_branch_target;
  logic [XLEN_P-1:0] w_jump_target;
  logic              w_branch_taken;
  pc_src_e           w_src;
  logic [XLEN_P-1:0] w_next;
  logic [XLEN_P-1:0] r_next_pc;

  pc_target_calc u_calc (
    .i_current_pc    (bus.current_pc),
    .i_ins_offset    (bus.ins_offset),
    .o_pc_plus4      (w_pc_plus4),
    .o_branch_target (w_branch_target),
    .o_jump_target   (w_jump_target)
  );

  // beq and bne together always resolve to a taken branch.
  assign w_branch_taken = (bus.con_beq  &  bus.zero_alu) |
                          (bus.con_bneq & ~bus.zero_alu);

  always_comb begin
    w_src = PC_SEQ;
    if (bus.con_jump)        w_src = PC_JUMP;
    else if (w_branch_taken) w_src = PC_BRANCH;
  end

  always_comb begin
    w_next = w_pc_plus4;
    case (w_src)
      PC_JUMP:   w_next = w_jump_target;
      PC_BRANCH: w_next = w_branch_target;
      default:   w_next = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_next_pc <= RESET_PC;
    else       r_next_pc <= w_next;
  end

  assign bus.next_pc = r_next_pc;
endmodule

// File: tb/tb_pc_update_unit.sv
// Directed-vector bench for pc_update_unit with hand-computed expectations.
module tb_pc_update_unit;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  pc_update_unit_if bus ();

  pc_update_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [25:0] off,
                       input logic z, input logic beq, input logic bne, input logic j);
    bus.current_pc = pc;
    bus.ins_offset = off;
    bus.zero_alu   = z;
    bus.con_beq    = beq;
    bus.con_bneq   = bne;
    bus.con_jump   = j;
  endtask

  task automatic vec(input string tag, input logic [31:0] pc, input logic [25:0] off,
                     input logic z, input logic beq, input logic bne, input logic j,
                     input logic [31:0] exp);
    drive(pc, off, z, beq, bne, j);
    @(posedge clk);
    #1;
    chk(tag, bus.next_pc, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(32'h00A94FB2, 26'h3A6F80, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_t0", bus.next_pc, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("reset_edge", bus.next_pc, 32'h0000_0000);
    reset = 1'b0;

    vec("seq",          32'h00A94FB2, 26'h3A6F80, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00A94FB6);
    vec("bne_taken",    32'h00A94FB2, 26'h3A6F80, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00AB0DB6);
    vec("bne_not",      32'h00A94FB2, 26'h3A6F80, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00A94FB6);
    vec("beq_taken",    32'h00A94FB2, 26'h3A6F80, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00AB0DB6);
    vec("beq_not",      32'h00A94FB2, 26'h3A6F80, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00A94FB6);
    vec("both_br_z1",   32'h00A94FB2, 26'h3A6F80, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00AB0DB6);
    vec("both_br_z0",   32'h00A94FB2, 26'h3A6F80, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00AB0DB6);
    vec("jump",         32'h00A94FB2, 26'h3A6F80, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00E9BE00);
    vec("jump_over_br", 32'h00A94FB2, 26'h3A6F80, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00E9BE00);
    vec("jump_hi",      32'hF0000000, 26'h0000001, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF0000004);
    vec("br_neg",       32'h00001000, 26'h000FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00001000);
    vec("br_neg_big",   32'h00001000, 26'h0008000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFE1004);
    vec("wrap",         32'hFFFFFFFC, 26'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000);
    vec("pre_reset",    32'h12345678, 26'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234567C);

    // Asynchronous reset between edges, held across two edges.
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", bus.next_pc, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", bus.next_pc, 32'h0000_0000);
    drive(32'h00000100, 26'h0000000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("deassert_hold", bus.next_pc, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("post_reset", bus.next_pc, 32'h00000104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
